instr_assembler: RTL

- Streaming RISC-V RV32I instruction encoder. It is the inverse of imm_generator: it takes decoded fields plus a full 32-bit immediate and packs them into a 32-bit instruction word.
- It expands the `li` pseudo-instruction into a LUI+ADDI pair.
- It sits in front of the instruction-memory loader and the self-checking benches, so test programs can be generated in simulation and in the boot loader.
- Both sides use a valid/ready handshake, with one output register.

---
 rtl/rv_isa_pkg.sv | 43 ++++
 rtl/imm_packer.sv | 44 ++++
 rtl/instr_assembler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants and request payload for the instruction assembler.
package rv_isa_pkg;

  localparam int unsigned XLEN_W = 32;
  localparam int unsigned FMT_W  = 3;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned LO_W   = 12;

  typedef enum logic [FMT_W-1:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_LI  = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [OPC_W-1:0]  OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0]  OP_OPIMM  = 7'b0010011;
  localparam logic [XLEN_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    fmt_e              fmt;
    logic [OPC_W-1:0]  opcode;
    logic [F3_W-1:0]   funct3;
    logic [F7_W-1:0]   funct7;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [XLEN_W-1:0] imm;
  } instr_req_t;

  // Signed range test of a full-width immediate.
  function automatic logic imm_in_range(input logic [XLEN_W-1:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/imm_packer.sv
// Combinational RV32I field packer with immediate range checking.
module imm_packer
  import rv_isa_pkg::*;
(
  input  instr_req_t         req,
  output logic [XLEN_W-1:0]  instr,
  output logic               range_err
);

  logic [XLEN_W-1:0] imm;
  assign imm = req.imm;

  always_comb begin
    instr     = NOP_INSTR;
    range_err = 1'b0;
    case (req.fmt)
      FMT_R: instr = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
      FMT_I: begin
        range_err = !imm_in_range(imm, -2048, 2047);
        instr     = {imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
      end
      FMT_S: begin
        range_err = !imm_in_range(imm, -2048, 2047);
        instr     = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], req.opcode};
      end
      FMT_B: begin
        range_err = !imm_in_range(imm, -4096, 4094) || imm[0];
        instr     = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3, imm[4:1], imm[11], req.opcode};
      end
      FMT_U: begin
        range_err = (imm[11:0] != 12'h000);
        instr     = {imm[31:12], req.rd, req.opcode};
      end
      FMT_J: begin
        range_err = !imm_in_range(imm, -1048576, 1048574) || imm[0];
        instr     = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, req.opcode};
      end
      default: range_err = 1'b1;
    endcase
    // Any rejected request collapses to a NOP word.
    if (range_err) instr = NOP_INSTR;
  end

endmodule

// File: rtl/instr_assembler.sv
// Streaming RV32I encoder: valid/ready in, one registered output word, li expanded to LUI+ADDI.
module instr_assembler
  import rv_isa_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          LI_SHORT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_fmt,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic            out_err,
  output logic            out_last
);

  typedef enum logic [1:0] {IDLE, EMIT, EMIT_HI} state_e;

  state_e             state_q, state_d;
  logic [REG_W-1:0]   rd_q, rd_d;
  logic [LO_W-1:0]    lo_q, lo_d;
  logic               valid_d, err_d, last_d;
  logic [XLEN_W-1:0]  instr_d;

  instr_req_t         pk_req;
  logic [XLEN_W-1:0]  pk_instr;
  logic               pk_err;

  logic               accept;
  logic               in_is_li, li_short, li_long;
  logic [XLEN_W-1:0]  imm_round;

  assign in_ready  = (state_q == IDLE) || ((state_q == EMIT) && out_ready);
  assign accept    = in_valid && in_ready;
  assign in_is_li  = (fmt_e'(in_fmt) == FMT_LI);
  assign li_short  = LI_SHORT && imm_in_range(in_imm, -2048, 2047);
  assign li_long   = in_is_li && !li_short;
  // Rounding so that hi<<12 plus the sign-extended lo reproduces the value mod 2^32.
  assign imm_round = in_imm + 32'h0000_0800;

  // Packer input select: pending ADDI, li translation, or plain pass-through.
  always_comb begin
    pk_req.fmt    = fmt_e'(in_fmt);
    pk_req.opcode = in_opcode;
    pk_req.funct3 = in_funct3;
    pk_req.funct7 = in_funct7;
    pk_req.rd     = in_rd;
    pk_req.rs1    = in_rs1;
    pk_req.rs2    = in_rs2;
    pk_req.imm    = in_imm;
    if (state_q == EMIT_HI) begin
      pk_req.fmt    = FMT_I;
      pk_req.opcode = OP_OPIMM;
      pk_req.funct3 = 3'd0;
      pk_req.funct7 = 7'd0;
      pk_req.rd     = rd_q;
      pk_req.rs1    = rd_q;
      pk_req.rs2    = 5'd0;
      pk_req.imm    = {{(XLEN_W-LO_W){lo_q[LO_W-1]}}, lo_q};
    end else if (in_is_li) begin
      pk_req.funct3 = 3'd0;
      pk_req.funct7 = 7'd0;
      pk_req.rs2    = 5'd0;
      if (li_short) begin
        pk_req.fmt    = FMT_I;
        pk_req.opcode = OP_OPIMM;
        pk_req.rs1    = 5'd0;
      end else begin
        pk_req.fmt    = FMT_U;
        pk_req.opcode = OP_LUI;
        pk_req.rs1    = 5'd0;
        pk_req.imm    = {imm_round[31:12], 12'h000};
      end
    end
  end

  imm_packer u_imm_packer (
    .req       (pk_req),
    .instr     (pk_instr),
    .range_err (pk_err)
  );

  // Next-state and output-register values.
  always_comb begin
    state_d = state_q;
    valid_d = out_valid;
    instr_d = out_instr;
    err_d   = out_err;
    last_d  = out_last;
    rd_d    = rd_q;
    lo_d    = lo_q;
    case (state_q)
      EMIT_HI: begin
        if (out_ready) begin
          state_d = EMIT;
          instr_d = pk_instr;
          err_d   = pk_err;
          last_d  = 1'b1;
        end
      end
      EMIT: begin
        if (out_ready && !in_valid) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (accept) begin
      valid_d = 1'b1;
      instr_d = pk_instr;
      err_d   = pk_err;
      if (li_long) begin
        state_d = EMIT_HI;
        last_d  = 1'b0;
        rd_d    = in_rd;
        lo_d    = in_imm[11:0];
      end else begin
        state_d = EMIT;
        last_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      out_instr <= NOP_INSTR;
      out_err   <= 1'b0;
      out_last  <= 1'b1;
      rd_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= valid_d;
      out_instr <= instr_d;
      out_err   <= err_d;
      out_last  <= last_d;
      rd_q      <= rd_d;
      lo_q      <= lo_d;
    end
  end

endmodule
